// File: rtl/data_cache_ctrl.sv
`timescale 1ns/1ps
// data_cache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller. Read hits are served combinationally; read misses refill a
// whole block word by word; every store is forwarded to main memory.
module data_cache_ctrl #(
    parameter int CACHE_LINES     = 32,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr31_0,
    input  logic [31:0] WriteData31_0,
    output logic [31:0] ReadData31_0,
    output logic        Stall,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int OFF  = $clog2(WORDS_PER_BLOCK);
    localparam int IDX  = $clog2(CACHE_LINES);
    localparam int TAGW = 30 - OFF - IDX;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        WDONE
    } state_t;

    state_t                state_q;
    logic [OFF-1:0]        cnt_q;
    logic [OFF-1:0]        cnt_nxt;
    logic [CACHE_LINES-1:0] valid_q;
    logic [TAGW-1:0]       tag_q  [CACHE_LINES];
    logic [31:0]           data_q [CACHE_LINES][WORDS_PER_BLOCK];
    logic                  rd_req_q;
    logic                  wr_req_q;
    logic [31:0]           addr_q;
    logic [31:0]           wdata_q;

    logic [OFF-1:0]        offset;
    logic [IDX-1:0]        index;
    logic [TAGW-1:0]       tag;
    logic                  hit;
    logic                  last_word;
    logic                  addr_lsb_unused;

    assign offset          = Addr31_0[OFF+1:2];
    assign index           = Addr31_0[OFF+IDX+1:OFF+2];
    assign tag             = Addr31_0[31:OFF+IDX+2];
    assign addr_lsb_unused = ^Addr31_0[1:0];

    assign hit       = valid_q[index] && (tag_q[index] == tag);
    assign cnt_nxt   = cnt_q + 1'b1;
    assign last_word = (cnt_q == OFF'(WORDS_PER_BLOCK - 1));

    assign ReadData31_0 = data_q[index][offset];
    assign mem_rd_req   = rd_req_q;
    assign mem_wr_req   = wr_req_q;
    // In WRITE the core holds its inputs, so address/data pass straight through.
    assign mem_addr     = (state_q == WRITE) ? {Addr31_0[31:2], 2'b00} : addr_q;
    assign mem_wdata    = (state_q == WRITE) ? WriteData31_0 : wdata_q;

    // Stall generation: combinational in IDLE, fixed per state otherwise.
    always_comb begin
        Stall = 1'b0;
        case (state_q)
            IDLE:    Stall = (MemRead && !hit) || MemWrite;
            REFILL:  Stall = 1'b1;
            WRITE:   Stall = 1'b1;
            WDONE:   Stall = 1'b0;
            default: Stall = 1'b0;
        endcase
    end

    // Controller FSM with registered memory-request outputs and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= '0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (MemWrite) begin
                        state_q  <= WRITE;
                        wr_req_q <= 1'b1;
                        addr_q   <= {Addr31_0[31:2], 2'b00};
                        wdata_q  <= WriteData31_0;
                    end else if (MemRead && !hit) begin
                        state_q        <= REFILL;
                        valid_q[index] <= 1'b0;
                        cnt_q          <= '0;
                        rd_req_q       <= 1'b1;
                        addr_q         <= {tag, index, {OFF{1'b0}}, 2'b00};
                    end
                end
                REFILL: begin
                    if (mem_ready) begin
                        cnt_q  <= cnt_nxt;
                        addr_q <= {tag, index, cnt_nxt, 2'b00};
                        if (last_word) begin
                            valid_q[index] <= 1'b1;
                            rd_req_q       <= 1'b0;
                            state_q        <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        wr_req_q <= 1'b0;
                        state_q  <= WDONE;
                    end
                end
                WDONE:   state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data arrays: store-hit update in IDLE, block fill during REFILL.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && MemWrite && hit) begin
            data_q[index][offset] <= WriteData31_0;
        end
        if (state_q == REFILL && mem_ready) begin
            data_q[index][cnt_q] <= mem_rdata;
            if (last_word) begin
                tag_q[index] <= tag;
            end
        end
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
`timescale 1ns/1ps
// tb_data_cache_ctrl: scoreboard bench for data_cache_ctrl with a main-memory
// model of configurable per-word latency.
module tb_data_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr31_0 = '0;
    logic [31:0] WriteData31_0 = '0;
    logic [31:0] ReadData31_0;
    logic        Stall;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    data_cache_ctrl #(.CACHE_LINES(32), .WORDS_PER_BLOCK(4)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .Addr31_0(Addr31_0), .WriteData31_0(WriteData31_0),
        .ReadData31_0(ReadData31_0), .Stall(Stall),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_ev_t;

    typedef struct {
        int unsigned stalls;
        bit          is_load;
        logic [31:0] data;
    } op_t;

    mem_ev_t     exp_mem[$];
    op_t         exp_op[$];
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned lat   = 1;
    logic [31:0] mem [logic [31:0]];

    localparam logic [31:0] A = 32'hAAAA_0001;
    localparam logic [31:0] B = 32'hBBBB_0002;
    localparam logic [31:0] C = 32'hCCCC_0003;
    localparam logic [31:0] D = 32'hDDDD_0004;
    localparam logic [31:0] E = 32'hEEEE_0005;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    // Memory model: completes a request after lat cycles, back-to-back when lat=1.
    int unsigned wcnt = 0;
    always @(negedge clk) begin
        if (!rst && (mem_rd_req || mem_wr_req)) begin
            wcnt++;
            if (wcnt == lat) begin
                wcnt      = 0;
                mem_ready = 1'b1;
                if (mem_rd_req) mem_rdata = mem_word(mem_addr);
                else            mem[mem_addr] = mem_wdata;
            end else begin
                mem_ready = 1'b0;
            end
        end else begin
            wcnt      = 0;
            mem_ready = 1'b0;
        end
    end

    // Monitor: pops expectations on memory completions and on retired core ops.
    int unsigned stall_cnt = 0;
    always begin
        mem_ev_t e;
        op_t     o;
        @(negedge clk);
        #1;
        if (rst) begin
            stall_cnt = 0;
        end else begin
            if (mem_ready && (mem_rd_req || mem_wr_req)) begin
                if (exp_mem.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mem_unexpected: got req rd=%0b wr=%0b addr %h, expected none",
                             mem_rd_req, mem_wr_req, mem_addr);
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_is_write", {31'd0, mem_wr_req}, {31'd0, e.wr});
                    check("mem_addr", mem_addr, e.addr);
                    if (e.wr) check("mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (MemRead || MemWrite) begin
                if (Stall) begin
                    stall_cnt++;
                end else begin
                    if (exp_op.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL op_unexpected: got retire at %h, expected none", Addr31_0);
                    end else begin
                        o = exp_op.pop_front();
                        check("stall_cycles", stall_cnt, o.stalls);
                        if (o.is_load) check("load_data", ReadData31_0, o.data);
                    end
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic push_refill(logic [31:0] base);
        mem_ev_t e;
        for (int unsigned i = 0; i < 4; i++) begin
            e.wr    = 1'b0;
            e.addr  = base + 32'(4 * i);
            e.wdata = '0;
            exp_mem.push_back(e);
        end
    endtask

    task automatic push_write(logic [31:0] a, logic [31:0] d);
        mem_ev_t e;
        e.wr    = 1'b1;
        e.addr  = a;
        e.wdata = d;
        exp_mem.push_back(e);
    endtask

    // Issue one core op (called #1 after a rising edge) and hold it until Stall drops.
    task automatic do_op(bit wr, logic [31:0] a, logic [31:0] d,
                         int unsigned stalls, logic [31:0] exp_data);
        op_t o;
        bit  done;
        o.stalls  = stalls;
        o.is_load = !wr;
        o.data    = exp_data;
        exp_op.push_back(o);
        Addr31_0      = a;
        WriteData31_0 = d;
        MemRead       = !wr;
        MemWrite      = wr;
        done          = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #2;
            if (!Stall) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_timeout: got Stall stuck at addr %h, expected release", a);
            finish_run();
        end
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin
        mem[32'h100] = A;
        mem[32'h104] = B;
        mem[32'h108] = C;
        mem[32'h10C] = D;
        mem[32'h300] = E;

        // Reset state and the IDLE stall equation while reset is held.
        #1;
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_rd_req", {31'd0, mem_rd_req}, 32'd0);
        check("rst_wr_req", {31'd0, mem_wr_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        MemRead  = 1'b1;
        Addr31_0 = 32'h100;
        #1;
        check("rst_stall_on_req", {31'd0, Stall}, 32'd1);
        MemRead = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold miss, then hit in the refilled block.
        lat = 1;
        push_refill(32'h100);
        do_op(1'b0, 32'h100, '0, 5, A);
        do_op(1'b0, 32'h10C, '0, 0, D);

        // Store hit with L=3, then read back from the cache.
        lat = 3;
        push_write(32'h108, 32'hDEAD_BEEF);
        do_op(1'b1, 32'h108, 32'hDEAD_BEEF, 4, '0);
        do_op(1'b0, 32'h108, '0, 0, 32'hDEAD_BEEF);

        // Store miss goes to memory only; the following load refills it.
        lat = 1;
        push_write(32'h2000, 32'h1234_5678);
        do_op(1'b1, 32'h2000, 32'h1234_5678, 2, '0);
        push_refill(32'h2000);
        do_op(1'b0, 32'h2000, '0, 5, 32'h1234_5678);

        // Conflict eviction on index 16.
        do_op(1'b0, 32'h100, '0, 0, A);
        push_refill(32'h300);
        do_op(1'b0, 32'h300, '0, 5, E);
        push_refill(32'h100);
        do_op(1'b0, 32'h100, '0, 5, A);
        push_refill(32'h300);
        do_op(1'b0, 32'h300, '0, 5, E);

        // Reset after two refill words of a miss on 0x100.
        exp_mem.push_back('{wr: 1'b0, addr: 32'h100, wdata: 32'h0});
        exp_mem.push_back('{wr: 1'b0, addr: 32'h104, wdata: 32'h0});
        Addr31_0 = 32'h100;
        MemRead  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_rd_req", {31'd0, mem_rd_req}, 32'd0);
        check("midrst_stall", {31'd0, Stall}, 32'd1);
        check("midrst_mem_q", exp_mem.size(), 32'd0);
        @(negedge clk);
        MemRead = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_refill(32'h100);
        do_op(1'b0, 32'h100, '0, 5, A);
        do_op(1'b0, 32'h108, '0, 0, 32'hDEAD_BEEF);
        push_refill(32'h2000);
        do_op(1'b0, 32'h2000, '0, 5, 32'h1234_5678);

        repeat (3) @(posedge clk);
        #1;
        check("end_mem_q", exp_mem.size(), 32'd0);
        check("end_op_q", exp_op.size(), 32'd0);
        finish_run();
    end

endmodule

// File: doc/data_cache_ctrl.md
# data_cache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller that responds to the core's load/store requests (MemRead/MemWrite from the main decoder, address from the ALU, store data from rs2). It serves read hits combinationally in the same cycle. On a read miss or any store it stalls the core, refills a 4-word block from main memory or forwards the write, then releases the stall. It sits between the single-cycle datapath and the main-memory model.

## Interface
- CACHE_LINES, 32, number of lines; power of two
- WORDS_PER_BLOCK, 4, words per line; power of two, ≥2
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- MemRead  in  1  load request from main decoder
- MemWrite  in  1  store request from main decoder
- Addr31_0  in  32  byte address; bits [1:0] ignored (word aligned)
- WriteData31_0  in  32  store data
- ReadData31_0  out  32  load data, valid when MemRead & ~Stall
- Stall  out  1  freeze PC/pipeline while high
- mem_rd_req  out  1  main-memory word read request, held until mem_ready
- mem_wr_req  out  1  main-memory word write request, held until mem_ready
- mem_addr  out  32  word-aligned main-memory address
- mem_wdata  out  32  main-memory write data
- mem_rdata  in  32  main-memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion pulse for the current request

## Operation
- Address split, with OFF = log2(WORDS_PER_BLOCK) and IDX = log2(CACHE_LINES):
  - word offset = Addr[OFF+1:2]
  - index = Addr[OFF+IDX+1:OFF+2]
  - tag = remaining upper bits
  - Defaults: offset [3:2], index [8:4], tag [31:9].
- Storage: valid bit, tag and data words per line. Hit = valid[index] & (tag match).
- States:
  - IDLE:
    - MemWrite has priority if both requests are asserted.
    - MemWrite → WRITE. If it is a hit, the cache word is updated on that edge.
    - MemRead miss → REFILL. On that edge: valid[index] cleared, word counter cleared.
    - MemRead hit → stay in IDLE.
  - REFILL:
    - mem_rd_req=1, mem_addr = {tag, index, cnt, 2'b00}.
    - On mem_ready: data[index][cnt] ← mem_rdata, cnt++.
    - On the mem_ready where cnt = WORDS_PER_BLOCK-1: tag[index] and valid[index] are set; go to IDLE.
  - WRITE: mem_wr_req=1, mem_addr = Addr (word-aligned), mem_wdata = WriteData31_0. On mem_ready → WDONE.
  - WDONE: Stall=0 for one cycle so the core retires the store without re-triggering; unconditionally → IDLE.
- Write miss: memory only; cache untouched (no allocate).
- ReadData31_0 = data[index][offset] combinationally, at all times.
- Stall:
  - IDLE: (MemRead & ~hit) | MemWrite, combinational.
  - REFILL and WRITE: 1.
  - WDONE: 0.
- Core holds Addr, MemRead/MemWrite and WriteData stable while Stall=1. mem_ready outside a request is ignored.

## Timing
- Reset values:
  - state=IDLE, cnt=0, all valid bits=0.
  - mem_rd_req=0, mem_wr_req=0, mem_addr=0, mem_wdata=0.
  - Stall follows the IDLE equation (1 for any request after reset until serviced).
  - Tag/data arrays are not reset.
- Read hit: 0 cycles, Stall=0 in the request cycle.
- Read miss with memory latency L cycles per word (request to mem_ready):
  - 1 IDLE cycle + WORDS_PER_BLOCK×L REFILL cycles + 1 IDLE hit cycle with Stall=0.
  - Default with L=1: stall for 5 cycles, data delivered in the 6th.
- Store: 1 IDLE cycle + L WRITE cycles with Stall=1, then 1 WDONE cycle with Stall=0.
- Request outputs change only on clock edges, except mem_addr/mem_wdata in WRITE, which follow the stable core inputs.
- Reset mid-REFILL or mid-WRITE: requests drop immediately (asynchronous), the line stays invalid, and the partial block is discarded.
- Conflict miss on a valid line: the old line is invalidated at REFILL entry; a write-through cache has no dirty data to flush.

## Test plan
- Reset, load 0x100 (memory words 0x100..0x10C = A,B,C,D), L=1 → Stall high 5 cycles, mem_rd_req addresses 0x100, 0x104, 0x108, 0x10C in order, then Stall=0 and ReadData=A.
- Then load 0x10C → Stall=0 same cycle, ReadData=D, mem_rd_req stays 0.
- Store 0x108 ← 0xDEADBEEF (hit), L=3 → mem_wr_req for 3 cycles at 0x108, WDONE cycle Stall=0. Then load 0x108 → hit, 0xDEADBEEF, no memory read.
- Store 0x2000 ← 0x12345678 (miss) → one memory write only. Then load 0x2000 → full refill from 0x2000 returning 0x12345678.
- Load 0x100, then load 0x300 (same index 16) → second refill evicts the line; a following load 0x100 misses and refills again.
- Assert rst after 2 refill words of load 0x100 → mem_rd_req drops the same cycle, Stall follows the IDLE equation. After release, load 0x100 performs a full 4-word refill starting at 0x100.
